// File: rtl/rf_scoreboard.sv
// rf_scoreboard: integer register file for miniRV with two async read
// ports, one sync write port, x0 hardwired to zero, an optional
// write-to-read bypass and a per-register busy scoreboard.
// Ports:
//   clk, rst (async, active-high)
//   rR1/rR2 -> rD1/rD2, busy1/busy2 : read data and pending-write flags
//   we/wR/wD                        : writeback port, clears busy
//   claim_en/claim_rd               : issue-stage destination claim
//   claim_err                       : sticky WAW claim error
module rf_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rR1,
  input  logic [AW-1:0]   rR2,
  output logic [XLEN-1:0] rD1,
  output logic [XLEN-1:0] rD2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we,
  input  logic [AW-1:0]   wR,
  input  logic [XLEN-1:0] wD,
  input  logic            claim_en,
  input  logic [AW-1:0]   claim_rd,
  output logic            claim_err
);

  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            claim_err_q;
  logic            claim_err_d;

  logic wr_ok;
  logic cl_ok;

  assign wr_ok = we && (wR != '0);
  assign cl_ok = claim_en && (claim_rd != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[wR] = wD;
    end
  end

  // Clear first so a same-index claim overrides the retiring write.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wR] = 1'b0;
    end
    if (cl_ok) begin
      busy_d[claim_rd] = 1'b1;
    end
  end

  // A claim on a busy reg is fine if that reg retires this cycle.
  always_comb begin
    claim_err_d = claim_err_q;
    if (cl_ok && busy_q[claim_rd] &&
        !(we && (wR == claim_rd))) begin
      claim_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      claim_err_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      claim_err_q <= claim_err_d;
    end
  end

  logic fwd1;
  logic fwd2;

  assign fwd1 = BP && we && (wR == rR1);
  assign fwd2 = BP && we && (wR == rR2);

  always_comb begin
    rD1   = '0;
    busy1 = 1'b0;
    if (!rst && (rR1 != '0)) begin
      if (fwd1) begin
        rD1 = wD;
      end else begin
        rD1   = regs_q[rR1];
        busy1 = busy_q[rR1];
      end
    end
  end

  always_comb begin
    rD2   = '0;
    busy2 = 1'b0;
    if (!rst && (rR2 != '0)) begin
      if (fwd2) begin
        rD2 = wD;
      end else begin
        rD2   = regs_q[rR2];
        busy2 = busy_q[rR2];
      end
    end
  end

  assign claim_err = claim_err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: drives a bypassing and a non-bypassing instance
// from one stimulus stream and compares both against an array model.
module tb_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rR1, rR2, wR, claim_rd;
  logic [31:0] wD;
  logic        we, claim_en;

  logic [31:0] rD1, rD2, nb_rD1, nb_rD2;
  logic        busy1, busy2, nb_busy1, nb_busy2;
  logic        claim_err, nb_claim_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_regs [32];
  logic        m_busy [32];
  logic        m_err;

  always #5 clk = ~clk;

  rf_scoreboard #(.XLEN(32), .NREG(32), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst),
    .rR1(rR1), .rR2(rR2), .rD1(rD1), .rD2(rD2),
    .busy1(busy1), .busy2(busy2),
    .we(we), .wR(wR), .wD(wD),
    .claim_en(claim_en), .claim_rd(claim_rd),
    .claim_err(claim_err)
  );

  rf_scoreboard #(.XLEN(32), .NREG(32), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst),
    .rR1(rR1), .rR2(rR2), .rD1(nb_rD1), .rD2(nb_rD2),
    .busy1(nb_busy1), .busy2(nb_busy2),
    .we(we), .wR(wR), .wD(wD),
    .claim_en(claim_en), .claim_rd(claim_rd),
    .claim_err(nb_claim_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] idx,
                                         input bit bp);
    if (rst || idx == 0) return 32'h0;
    if (bp && we && wR == idx) return wD;
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] idx,
                                           input bit bp);
    if (rst || idx == 0) return 32'h0;
    if (bp && we && wR == idx) return 32'h0;
    return {31'b0, m_busy[idx]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) return;
    if (claim_en && claim_rd != 0 && m_busy[claim_rd] &&
        !(we && wR == claim_rd))
      m_err = 1'b1;
    if (we && wR != 0) begin
      m_regs[wR] = wD;
      m_busy[wR] = 1'b0;
    end
    if (claim_en && claim_rd != 0)
      m_busy[claim_rd] = 1'b1;
  endtask

  task automatic check_all();
    chk("rd1",     rD1,              exp_rd(rR1, 1));
    chk("rd2",     rD2,              exp_rd(rR2, 1));
    chk("busy1",   32'(busy1),       exp_busy(rR1, 1));
    chk("busy2",   32'(busy2),       exp_busy(rR2, 1));
    chk("err",     32'(claim_err),   32'(m_err));
    chk("nb_rd1",  nb_rD1,           exp_rd(rR1, 0));
    chk("nb_rd2",  nb_rD2,           exp_rd(rR2, 0));
    chk("nb_bsy1", 32'(nb_busy1),    exp_busy(rR1, 0));
    chk("nb_bsy2", 32'(nb_busy2),    exp_busy(rR2, 0));
    chk("nb_err",  32'(nb_claim_err), 32'(m_err));
  endtask

  // Called at posedge+1; leaves inputs applied and checks at mid-cycle.
  task automatic drive(input logic       iwe,
                       input logic [4:0] iwr,
                       input logic [31:0] iwd,
                       input logic       ice,
                       input logic [4:0] icrd,
                       input logic [4:0] ir1,
                       input logic [4:0] ir2);
    we = iwe; wR = iwr; wD = iwd;
    claim_en = ice; claim_rd = icrd;
    rR1 = ir1; rR2 = ir2;
    #4;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    we = 0; wR = 0; wD = 0; claim_en = 0; claim_rd = 0;
    rR1 = 0; rR2 = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 32; i += 4) begin
      drive(1, 5'(i), 32'hFFFF_FFFF, 1, 5'(i), 5'(i), 5'(31 - i));
      chk("rst_rd1", rD1, 32'h0);
      chk("rst_bsy2", 32'(busy2), 32'h0);
      tick();
    end
    rst = 1'b0;

    drive(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("x0_zero", rD1, 32'h0);
    tick();

    drive(1, 5, 32'h1234_5678, 0, 0, 5, 5);
    chk("byp_rd1", rD1, 32'h1234_5678);
    chk("nobyp_rd1", nb_rD1, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 5, 0);
    chk("nobyp_nxt", nb_rD1, 32'h1234_5678);
    tick();

    drive(0, 0, 0, 1, 7, 0, 7);
    chk("claim_now", 32'(busy2), 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 7);
    chk("claim_nxt", 32'(busy2), 32'h1);
    tick();
    drive(1, 7, 32'hA5A5_A5A5, 0, 0, 0, 7);
    chk("byp_bsy2", 32'(busy2), 32'h0);
    chk("nb_bsy2w", 32'(nb_busy2), 32'h1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 7);
    chk("x7_data", rD2, 32'hA5A5_A5A5);
    chk("x7_free", 32'(busy2), 32'h0);
    tick();

    drive(0, 0, 0, 1, 9, 0, 0);
    tick();
    drive(1, 9, 32'h0000_0099, 1, 9, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 9, 9);
    chk("x9_data", nb_rD1, 32'h99);
    chk("x9_busy", 32'(busy1), 32'h1);
    chk("x9_noerr", 32'(claim_err), 32'h0);
    tick();

    drive(0, 0, 0, 1, 3, 0, 0);
    tick();
    drive(0, 0, 0, 1, 3, 0, 0);
    tick();
    drive(1, 3, 32'h3, 0, 0, 3, 0);
    chk("waw_err", 32'(claim_err), 32'h1);
    tick();
    drive(1, 6, 32'h6, 1, 8, 3, 6);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("err_hold", 32'(claim_err), 32'h1);
    tick();

    drive(1, 4, 32'h55, 1, 4, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 4, 4);
    chk("x4_pre", nb_rD1, 32'h55);
    chk("x4_bpre", 32'(busy1), 32'h1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("x4_rst", rD1, 32'h0);
    chk("x4_brst", 32'(busy2), 32'h0);
    chk("err_rst", 32'(claim_err), 32'h0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 4, 4);
    chk("x4_clr", nb_rD1, 32'h0);
    tick();
    drive(1, 4, 32'h66, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 4, 0);
    chk("x4_new", rD1, 32'h66);
    tick();

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] a, b, c, d;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      a = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      b = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      c = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      d = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      drive(($urandom_range(0, 9) < 4), a, $urandom,
            ($urandom_range(0, 9) < 3), b, c, d);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
